// File: rtl/conv_seq.sv
`default_nettype none
// ============================================================================
// Module : conv_seq
// Layer sequencer for the 5x5 conv datapath: header fetch, kernel and window
// loads, per-output-channel writes with read-modify-write accumulation.
// Rev    : 1.0
// ============================================================================
module conv_seq #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 32,
  parameter int HDR_ADDR   = 0,
  parameter int KNL_BASE   = 16,
  parameter int IFMAP_BASE = 8192,
  parameter int OFMAP_BASE = 65536
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  enable,
  input  logic                  dram_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [ADDR_WIDTH-1:0] addr_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  dram_en_rd,
  output logic                  dram_en_wr,
  output logic                  done,
  output logic                  err,
  output logic                  en_ld_knl,
  output logic                  en_ld_ifmap,
  output logic                  disable_acc,
  output logic [5:0]            num_knls,
  output logic [4:0]            cnt_ofmap_chnl
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LD_KNL, S_LD_WIN, S_SEL, S_WR, S_ACC, S_DONE
  } state_t;

  state_t r_state, w_state_nxt;

  logic [1:0]            r_hcnt;
  logic [5:0]            r_k, r_c, r_w, r_h;
  logic [5:0]            r_ic, r_ox, r_oy;
  logic [4:0]            r_oc;
  logic [9:0]            r_n;
  logic [2:0]            r_row, r_col;
  logic [ADDR_WIDTH-1:0] r_knl_ptr, r_chnl_base;
  logic                  r_err;

  logic [5:0]            w_hdr_field, w_ow, w_oh;
  logic                  w_hdr_ok, w_fire, w_oc_last, w_ox_last, w_oy_last;
  logic                  w_ic_last, w_knl_last, w_win_last;
  logic [ADDR_WIDTH-1:0] w_a_w, w_a_h, w_a_ow, w_a_oh, w_a_ox, w_a_oy;
  logic [ADDR_WIDTH-1:0] w_win_addr, w_ofm_addr, w_hdr_addr;
  logic                  w_unused;

  assign w_unused    = ^data_in[DATA_WIDTH-1:6];
  assign w_hdr_field = data_in[5:0];

  // The 4th header word (H) is validated straight off the bus in its valid cycle.
  assign w_hdr_ok = (r_k >= 6'd1) && (r_k <= 6'd16) &&
                    (r_c >= 6'd1) && (r_c <= 6'd32) &&
                    (r_w >= 6'd5) && (r_w <= 6'd32) &&
                    (w_hdr_field >= 6'd5) && (w_hdr_field <= 6'd32);

  assign w_ow       = r_w - 6'd4;
  assign w_oh       = r_h - 6'd4;
  assign w_oc_last  = ({1'b0, r_oc} == r_k - 6'd1);
  assign w_ox_last  = (r_ox == w_ow - 6'd1);
  assign w_oy_last  = (r_oy == w_oh - 6'd1);
  assign w_ic_last  = (r_ic == r_c - 6'd1);
  assign w_knl_last = (r_n == 10'(r_k) * 10'd25 - 10'd1);
  assign w_win_last = (r_row == 3'd4) && (r_col == 3'd4);

  assign w_a_w  = ADDR_WIDTH'(r_w);
  assign w_a_h  = ADDR_WIDTH'(r_h);
  assign w_a_ow = ADDR_WIDTH'(w_ow);
  assign w_a_oh = ADDR_WIDTH'(w_oh);
  assign w_a_ox = ADDR_WIDTH'(r_ox);
  assign w_a_oy = ADDR_WIDTH'(r_oy);

  assign w_hdr_addr = ADDR_WIDTH'(HDR_ADDR) + ADDR_WIDTH'(r_hcnt);
  assign w_win_addr = r_chnl_base + (w_a_oy + ADDR_WIDTH'(r_row)) * w_a_w
                    + w_a_ox + ADDR_WIDTH'(r_col);
  assign w_ofm_addr = ADDR_WIDTH'(OFMAP_BASE) + ADDR_WIDTH'(r_oc) * w_a_ow * w_a_oh
                    + w_a_oy * w_a_ow + w_a_ox;

  assign w_fire   = dram_en_rd & dram_valid;
  assign num_knls = r_k;

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    addr_in        = '0;
    addr_out       = '0;
    dram_en_rd     = 1'b0;
    dram_en_wr     = 1'b0;
    done           = 1'b0;
    err            = 1'b0;
    en_ld_knl      = 1'b0;
    en_ld_ifmap    = 1'b0;
    disable_acc    = 1'b0;
    cnt_ofmap_chnl = '0;
    case (r_state)
      S_IDLE: if (enable) w_state_nxt = S_HDR;
      S_HDR: begin
        dram_en_rd = enable;
        addr_in    = w_hdr_addr;
        if (w_fire && r_hcnt == 2'd3) w_state_nxt = w_hdr_ok ? S_LD_KNL : S_DONE;
      end
      S_LD_KNL: begin
        dram_en_rd = enable;
        addr_in    = r_knl_ptr;
        en_ld_knl  = w_fire;
        if (w_fire && w_knl_last) w_state_nxt = S_LD_WIN;
      end
      S_LD_WIN: begin
        dram_en_rd  = enable;
        addr_in     = w_win_addr;
        en_ld_ifmap = w_fire;
        if (w_fire && w_win_last) w_state_nxt = S_SEL;
      end
      S_SEL: begin
        addr_out       = w_ofm_addr;
        cnt_ofmap_chnl = r_oc;
        disable_acc    = (r_ic == 6'd0);
        w_state_nxt    = (r_ic == 6'd0) ? S_WR : S_ACC;
      end
      S_WR, S_ACC: begin
        addr_out       = w_ofm_addr;
        cnt_ofmap_chnl = r_oc;
        disable_acc    = (r_ic == 6'd0);
        if (r_state == S_ACC) begin
          dram_en_rd = enable;
          addr_in    = w_ofm_addr;
          dram_en_wr = enable & dram_valid;
        end else begin
          dram_en_wr = enable;
        end
        if (dram_en_wr) begin
          if (!w_oc_last)                   w_state_nxt = S_SEL;
          else if (!(w_ox_last && w_oy_last)) w_state_nxt = S_LD_WIN;
          else if (!w_ic_last)              w_state_nxt = S_LD_KNL;
          else                              w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        err  = r_err;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (!enable) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      r_hcnt      <= '0;
      r_k         <= '0;
      r_c         <= '0;
      r_w         <= '0;
      r_h         <= '0;
      r_ic        <= '0;
      r_oc        <= '0;
      r_ox        <= '0;
      r_oy        <= '0;
      r_n         <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_knl_ptr   <= '0;
      r_chnl_base <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (enable) begin
          r_hcnt      <= '0;
          r_k         <= '0;
          r_c         <= '0;
          r_w         <= '0;
          r_h         <= '0;
          r_ic        <= '0;
          r_oc        <= '0;
          r_ox        <= '0;
          r_oy        <= '0;
          r_n         <= '0;
          r_row       <= '0;
          r_col       <= '0;
          r_knl_ptr   <= ADDR_WIDTH'(KNL_BASE);
          r_chnl_base <= ADDR_WIDTH'(IFMAP_BASE);
          r_err       <= 1'b0;
        end
        S_HDR: if (w_fire) begin
          case (r_hcnt)
            2'd0:    r_k <= w_hdr_field;
            2'd1:    r_c <= w_hdr_field;
            2'd2:    r_w <= w_hdr_field;
            default: begin
              r_h   <= w_hdr_field;
              r_err <= !w_hdr_ok;
            end
          endcase
          r_hcnt <= r_hcnt + 2'd1;
        end
        // Kernels of successive input channels are contiguous, so one pointer suffices.
        S_LD_KNL: if (w_fire) begin
          r_knl_ptr <= r_knl_ptr + ADDR_WIDTH'(1);
          r_n       <= w_knl_last ? 10'd0 : r_n + 10'd1;
        end
        S_LD_WIN: if (w_fire) begin
          if (r_row == 3'd4) begin
            r_row <= '0;
            r_col <= (r_col == 3'd4) ? 3'd0 : r_col + 3'd1;
          end else begin
            r_row <= r_row + 3'd1;
          end
        end
        S_WR, S_ACC: if (dram_en_wr) begin
          if (!w_oc_last) begin
            r_oc <= r_oc + 5'd1;
          end else begin
            r_oc <= '0;
            if (!w_ox_last) begin
              r_ox <= r_ox + 6'd1;
            end else begin
              r_ox <= '0;
              if (!w_oy_last) begin
                r_oy <= r_oy + 6'd1;
              end else begin
                r_oy        <= '0;
                r_ic        <= r_ic + 6'd1;
                r_chnl_base <= r_chnl_base + w_a_w * w_a_h;
              end
            end
          end
        end
        S_DONE: if (!enable) r_err <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_conv_seq
// Directed layers for conv_seq, checked against a loop-nest model of its DRAM traffic.
// Rev    : 1.0
// ============================================================================
module tb_conv_seq;
  localparam int AW = 18;
  localparam int KB = 16;
  localparam int IB = 8192;
  localparam int OB = 65536;

  logic          clk = 1'b0, srstn = 1'b0, enable = 1'b0, dram_valid = 1'b0;
  logic [31:0]   data_in = '0;
  logic [AW-1:0] addr_in, addr_out;
  logic          dram_en_rd, dram_en_wr, done, err, en_ld_knl, en_ld_ifmap, disable_acc;
  logic [5:0]    num_knls;
  logic [4:0]    cnt_ofmap_chnl;

  always #5 clk = ~clk;

  conv_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .HDR_ADDR(0), .KNL_BASE(KB),
             .IFMAP_BASE(IB), .OFMAP_BASE(OB)) dut (
    .clk(clk), .srstn(srstn), .enable(enable), .dram_valid(dram_valid),
    .data_in(data_in), .addr_in(addr_in), .addr_out(addr_out),
    .dram_en_rd(dram_en_rd), .dram_en_wr(dram_en_wr), .done(done), .err(err),
    .en_ld_knl(en_ld_knl), .en_ld_ifmap(en_ld_ifmap), .disable_acc(disable_acc),
    .num_knls(num_knls), .cnt_ofmap_chnl(cnt_ofmap_chnl));

  typedef struct { int addr; int kind; } rd_t;          // kind: 0 hdr, 1 knl, 2 win, 3 acc
  typedef struct { int addr; int oc; bit dis; bit acc; } wr_t;

  int  n_chk = 0, n_fail = 0;
  rd_t exp_rd[$];
  wr_t exp_wr[$];
  int  obs_rd[$], obs_wr[$], obs_oc[$];
  bit  obs_dis[$];
  int  hdr [4];
  int  gap_mode = 0, gap_fix = 1;
  bit  pend = 0;
  int  wcnt = 0, ra = 0;
  int  knl_pulses = 0, win_pulses = 0;
  bit  prev_rd = 0, prev_acc = 0, acc_c = 0;
  logic [AW-1:0] prev_addr = '0;
  longint last_acc_t = 0, last_wr_t = 0;
  rd_t cur_r;
  wr_t cur_w;

  task automatic check(input string name, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic bit hdr_valid(input int k, input int c, input int w, input int h);
    return k >= 1 && k <= 16 && c >= 1 && c <= 32 && w >= 5 && w <= 32 && h >= 5 && h <= 32;
  endfunction

  task automatic push_rd(input int a, input int kind);
    rd_t t;
    t.addr = a; t.kind = kind;
    exp_rd.push_back(t);
  endtask

  task automatic push_wr(input int a, input int oc, input bit dis, input bit acc);
    wr_t t;
    t.addr = a; t.oc = oc; t.dis = dis; t.acc = acc;
    exp_wr.push_back(t);
  endtask

  // Expected DRAM traffic of one layer, written as the plain loop nest of the algorithm.
  task automatic build_model(input int k, input int c, input int w, input int h);
    int ow, oh, a;
    exp_rd.delete(); exp_wr.delete();
    obs_rd.delete(); obs_wr.delete(); obs_oc.delete(); obs_dis.delete();
    knl_pulses = 0; win_pulses = 0;
    hdr[0] = k; hdr[1] = c; hdr[2] = w; hdr[3] = h;
    for (int i = 0; i < 4; i++) push_rd(i, 0);
    if (!hdr_valid(k, c, w, h)) return;
    ow = w - 4; oh = h - 4;
    for (int ic = 0; ic < c; ic++) begin
      for (int n = 0; n < k * 25; n++) push_rd(KB + ic * k * 25 + n, 1);
      for (int oy = 0; oy < oh; oy++)
        for (int ox = 0; ox < ow; ox++) begin
          for (int col = 0; col < 5; col++)
            for (int row = 0; row < 5; row++)
              push_rd(IB + ic * w * h + (oy + row) * w + ox + col, 2);
          for (int oc = 0; oc < k; oc++) begin
            a = OB + oc * ow * oh + oy * ow + ox;
            if (ic > 0) push_rd(a, 3);
            push_wr(a, oc, ic == 0, ic > 0);
          end
        end
    end
  endtask

  // DRAM responder, then the per-cycle compare against the model.
  always @(negedge clk) begin
    if (!dram_en_rd) begin
      pend       = 1'b0;
      dram_valid = (gap_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end else begin
      if (!pend) begin
        pend = 1'b1;
        wcnt = (gap_mode == 1) ? int'($urandom_range(0, 7)) : gap_fix;
      end
      if (wcnt == 0) begin dram_valid = 1'b1; pend = 1'b0; end
      else begin dram_valid = 1'b0; wcnt--; end
    end
    ra      = int'(addr_in);
    data_in = (dram_en_rd && ra < 4) ? 32'(hdr[ra]) : 32'h0001_0000;
    #1;
    acc_c = dram_en_rd && dram_valid;
    if (prev_rd && !prev_acc && dram_en_rd) check("addr_in_hold", addr_in, prev_addr);
    if (acc_c) begin
      obs_rd.push_back(int'(addr_in));
      last_acc_t = $time;
      if (exp_rd.size() == 0) check("extra_read", addr_in, -1);
      else begin
        cur_r = exp_rd.pop_front();
        check("rd_addr", addr_in, cur_r.addr);
        check("en_ld_knl", en_ld_knl, cur_r.kind == 1);
        check("en_ld_ifmap", en_ld_ifmap, cur_r.kind == 2);
      end
    end else begin
      check("idle_load_strobe", {en_ld_knl, en_ld_ifmap}, 0);
    end
    if (dram_en_wr) begin
      obs_wr.push_back(int'(addr_out));
      obs_oc.push_back(int'(cnt_ofmap_chnl));
      obs_dis.push_back(disable_acc);
      last_wr_t = $time;
      if (exp_wr.size() == 0) check("extra_write", addr_out, -1);
      else begin
        cur_w = exp_wr.pop_front();
        check("wr_addr", addr_out, cur_w.addr);
        check("wr_chnl", cnt_ofmap_chnl, cur_w.oc);
        check("disable_acc", disable_acc, cur_w.dis);
        check("rd_wr_overlap", acc_c, cur_w.acc);
      end
    end
    knl_pulses += int'(en_ld_knl);
    win_pulses += int'(en_ld_ifmap);
    prev_rd   = dram_en_rd;
    prev_acc  = acc_c;
    prev_addr = addr_in;
  end

  task automatic check_all_zero(input string name, input bit with_knls);
    check({name, "_ctrl"}, {dram_en_rd, dram_en_wr, done, err, en_ld_knl, en_ld_ifmap, disable_acc}, 0);
    check({name, "_addr_in"}, addr_in, 0);
    check({name, "_addr_out"}, addr_out, 0);
    check({name, "_chnl"}, cnt_ofmap_chnl, 0);
    if (with_knls) check({name, "_num_knls"}, num_knls, 0);
  endtask

  task automatic run_layer(input string tag, input int k, input int c, input int w,
                           input int h, input int budget);
    int cyc = 0;
    bit ok;
    ok = hdr_valid(k, c, w, h);
    build_model(k, c, w, h);
    @(posedge clk); #3; enable = 1'b1;
    while (!done && cyc < budget) begin @(posedge clk); #3; cyc++; end
    check({tag, "_done"}, done, 1);
    if (done) begin
      if (ok) check({tag, "_done_latency"}, $time - last_wr_t, 7);
      else    check({tag, "_err_latency"}, $time - last_acc_t, 7);
    end
    check({tag, "_err"}, err, !ok);
    check({tag, "_num_knls"}, num_knls, k & 63);
    check({tag, "_reads_left"}, exp_rd.size(), 0);
    check({tag, "_writes_left"}, exp_wr.size(), 0);
    @(posedge clk); #3;
    check({tag, "_done_held"}, done, 1);
    check({tag, "_err_held"}, err, !ok);
    enable = 1'b0;
    @(posedge clk); #3;
    check({tag, "_done_clr"}, done, 0);
    check({tag, "_err_clr"}, err, 0);
  endtask

  initial begin : stim
    int cyc;
    int t2_addr [4];
    int t2_oc   [4];
    t2_addr = '{65536, 65538, 65537, 65539};
    t2_oc   = '{0, 1, 0, 1};

    #12; check_all_zero("reset", 1'b1);
    @(posedge clk); #3; srstn = 1'b1;
    @(posedge clk); #3; check_all_zero("idle", 1'b1);

    gap_mode = 0; gap_fix = 1;
    run_layer("t1", 1, 1, 5, 5, 2000);
    check("t1_reads", obs_rd.size(), 54);
    check("t1_writes", obs_wr.size(), 1);
    if (obs_wr.size() >= 1) begin
      check("t1_wr_addr_lit", obs_wr[0], 65536);
      check("t1_disable_acc_lit", obs_dis[0], 1);
    end

    run_layer("t2", 2, 1, 6, 5, 3000);
    check("t2_writes", obs_wr.size(), 4);
    for (int i = 0; i < 4 && i < obs_wr.size(); i++) begin
      check("t2_wr_addr_lit", obs_wr[i], t2_addr[i]);
      check("t2_chnl_lit", obs_oc[i], t2_oc[i]);
    end

    run_layer("t3", 1, 2, 5, 5, 3000);
    check("t3_reads", obs_rd.size(), 105);
    if (obs_rd.size() >= 105) begin
      check("t3_knl_first_lit", obs_rd[54], 41);
      check("t3_knl_last_lit", obs_rd[78], 65);
      check("t3_win_first_lit", obs_rd[79], 8217);
      check("t3_win_last_lit", obs_rd[103], 8241);
      check("t3_acc_rd_lit", obs_rd[104], 65536);
    end
    check("t3_writes", obs_wr.size(), 2);
    if (obs_wr.size() >= 2) begin
      check("t3_acc_wr_lit", obs_wr[1], 65536);
      check("t3_acc_dis_lit", obs_dis[1], 0);
    end

    gap_mode = 1;
    run_layer("rand", 3, 2, 6, 6, 20000);
    check("rand_knl_pulses", knl_pulses, 150);
    check("rand_win_pulses", win_pulses, 200);

    gap_mode = 0;
    run_layer("bad_k0", 0, 1, 5, 5, 200);
    run_layer("bad_k17", 17, 1, 5, 5, 200);
    run_layer("bad_w4", 1, 1, 4, 5, 200);
    check("bad_no_loads", knl_pulses + win_pulses, 0);

    // Abort in the middle of a window load.
    build_model(1, 1, 5, 5);
    @(posedge clk); #3; enable = 1'b1;
    cyc = 0;
    while (obs_rd.size() < 35 && cyc < 2000) begin @(posedge clk); #3; cyc++; end
    check("abort_reached_win", obs_rd.size() >= 35, 1);
    enable = 1'b0;
    exp_rd.delete(); exp_wr.delete();
    @(negedge clk); #2;
    check("abort_strobes", {dram_en_rd, dram_en_wr, en_ld_knl, en_ld_ifmap}, 0);
    @(posedge clk); #3;
    check_all_zero("abort_idle", 1'b0);
    run_layer("restart1", 1, 1, 5, 5, 2000);

    // Asynchronous reset while an accumulate read is outstanding.
    build_model(1, 2, 5, 5);
    @(posedge clk); #3; enable = 1'b1;
    cyc = 0;
    while (!(dram_en_rd && addr_in == AW'(OB)) && cyc < 3000) begin @(posedge clk); #3; cyc++; end
    check("rst_reached_acc", dram_en_rd && addr_in == AW'(OB), 1);
    srstn = 1'b0; enable = 1'b0;
    exp_rd.delete(); exp_wr.delete();
    #1; check_all_zero("rst_async", 1'b1);
    @(negedge clk); #2;
    check_all_zero("rst_hold", 1'b1);
    check("rst_no_acc_write", obs_wr.size(), 1);
    @(posedge clk); #3; srstn = 1'b1;
    run_layer("restart2", 1, 2, 5, 5, 3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_seq.md
Name: conv_seq

Overview:
- Layer sequencer for the 5x5 convolution datapath: kernel shift buffer (16x25 words), 25-word window buffer and a registered MAC whose output is `mac_ff`.
- Reads a layer header from DRAM, then loads kernels per input channel and slides windows across the input feature map.
- Steps through output channels and writes results to DRAM; for input channels after the first it does read-modify-write accumulation.
- Sits between the DRAM port and the conv datapath; the datapath's `data_out` drives DRAM write data.

Parameters:
- ADDR_WIDTH, 18, DRAM word address width.
- DATA_WIDTH, 32, DRAM word width.
- HDR_ADDR, 0, address of the 4-word layer header.
- KNL_BASE, 16, base address of the kernels.
- IFMAP_BASE, 8192, base address of the input feature map.
- OFMAP_BASE, 65536, base address of the output feature map.

Ports:
- clk  in  1  clock.
- srstn  in  1  asynchronous active-low reset.
- enable  in  1  level start; deassert to abort or clear done.
- dram_valid  in  1  read data valid on data_in this cycle.
- data_in  in  32  DRAM read data; header fields only are used here.
- addr_in  out  ADDR_WIDTH  DRAM read address.
- addr_out  out  ADDR_WIDTH  DRAM write address.
- dram_en_rd  out  1  read request, held until dram_valid.
- dram_en_wr  out  1  single-cycle write strobe.
- done  out  1  layer complete, held until enable low.
- err  out  1  header invalid, held with done.
- en_ld_knl  out  1  shift data_in into kernel buffer.
- en_ld_ifmap  out  1  shift data_in into window buffer.
- disable_acc  out  1  1 = write mac_ff directly, 0 = data_in+mac_ff.
- num_knls  out  6  number of output channels (1..16).
- cnt_ofmap_chnl  out  5  output channel currently selected.

Behaviour:
- Reset (async): state IDLE; all outputs 0. disable_acc also resets to 0.
- Header (words 0..3 at HDR_ADDR+0..3, bits[5:0]): K = num_knls, C = input channels, W = width, H = height.
- Header is valid iff 1<=K<=16, 1<=C<=32, 5<=W<=32, 5<=H<=32. Otherwise go to DONE with err=1.
- Output size: OW = W-4, OH = H-4. All address arithmetic is unsigned, ADDR_WIDTH bits, wraps modulo 2^ADDR_WIDTH.
- Read handshake: dram_en_rd=1 with addr_in stable until the cycle dram_valid=1. That cycle is consumed (load strobe or write), and the next request may start the following cycle. dram_valid while dram_en_rd=0 is ignored.
- en_ld_knl / en_ld_ifmap are combinational: dram_en_rd & dram_valid & (state==LD_KNL / LD_WIN).
- State IDLE -> HDR when enable=1.
- HDR: 4 reads. Latch fields. Validate -> LD_KNL (ic=0) or DONE (err=1).
- LD_KNL: K*25 reads from KNL_BASE + ic*K*25 + n, n=0..K*25-1 ascending -> LD_WIN (oy=ox=0 when ic changes).
- LD_WIN: 25 reads, column-major: for c=0..4, for r=0..4, addr = IFMAP_BASE + ic*W*H + (oy+r)*W + (ox+c) -> SEL (oc=0).
- SEL: cnt_ofmap_chnl=oc for one cycle, letting mac_ff settle -> WR if ic==0, else ACC.
- WR: dram_en_wr=1 for 1 cycle, addr_out = OFMAP_BASE + oc*OW*OH + oy*OW + ox.
- ACC: dram_en_rd=1 with addr_in = addr_out (same formula). On dram_valid, dram_en_wr=1 in the same cycle.
- After a write:
  - if oc<K-1: oc++, go to SEL.
  - else advance ox, then oy. Next window -> LD_WIN.
  - else ic++ -> LD_KNL.
  - else -> DONE.
- cnt_ofmap_chnl and disable_acc (= ic==0) stay stable from SEL through the write.
- num_knls = latched K (0 before the header is read).
- DONE: done=1, no DRAM activity. enable=0 -> IDLE next cycle, clearing done and err.
- enable=0 in any busy state: abort to IDLE next cycle. Outstanding read is dropped, strobes are 0.
- Reset mid-operation: immediate IDLE; a pending read is abandoned.
- Write and read never overlap except in the ACC valid cycle.

Test Plan:
- Header K=1, C=1, W=H=5, dram_valid 1 cycle after each request, all data 1.0 (0x00010000) -> 4+25+25 reads, exactly one write at 65536 with disable_acc=1, done after it.
- K=2, C=1, W=6, H=5 -> OW=2, OH=1. Writes in order 65536, 65538, 65537, 65539. cnt_ofmap_chnl toggles 0,1,0,1.
- K=1, C=2, W=H=5 -> second channel kernel reads at 41..65, window reads at 8217..8241. ACC reads 65536 and writes it in the same valid cycle, disable_acc=0.
- Random dram_valid gaps of 0..7 cycles -> addr_in held stable, en_ld_* pulse count exactly K*25 and 25 per window, no extra strobes.
- Header K=0, or K=17, or W=4 -> done=1 and err=1 after the 4th header read, no load strobes. enable low -> done=err=0 next cycle.
- Drop enable mid LD_WIN; separately assert srstn=0 mid ACC -> IDLE, all outputs 0, no write issued, restart completes normally.
